mult_div_unit: RTL and testbench

//   Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.

---
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU): radix-2 shift-add multiplier, restoring divider.
// Optional macro MDU_ZERO_SKIP_EN: multiplies with a zero operand finish in one cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state;
  logic               is_div;
  logic               b_zero;
  logic               neg_res;
  logic               neg_rem;
  logic               dz_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;

  logic               in_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               zero_skip;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] mul_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes and signs; op[0] = 0 selects the signed variants.
  always_comb begin
    in_signed = ~op[0];
    a_neg     = in_signed & a[WIDTH-1];
    b_neg     = in_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  always_comb begin
    zero_skip = 1'b0;
`ifdef MDU_ZERO_SKIP_EN
    zero_skip = ~op[1] && ((a == '0) || (b == '0));
`endif
  end

  // prod holds {accumulator, multiplier} for mult and {remainder, quotient} for div.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, prod[WIDTH-1:1]};
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (div_diff[WIDTH])
      div_next = {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    mul_fix = neg_res ? -prod : prod;
    quo_fix = neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem_fix = neg_rem ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      is_div  <= 1'b0;
      b_zero  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz_q    <= 1'b0;
      cnt     <= '0;
      a_q     <= '0;
      mcand   <= '0;
      prod    <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div  <= op[1];
            b_zero  <= (b == '0);
            a_q     <= a;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            cnt     <= CW'(WIDTH);
            if (op[1]) begin
              prod  <= {{WIDTH{1'b0}}, a_mag};
              mcand <= b_mag;
            end else begin
              prod  <= {{WIDTH{1'b0}}, b_mag};
              mcand <= a_mag;
            end
            if (zero_skip) begin
              hi    <= '0;
              lo    <= '0;
              dz_q  <= 1'b0;
              state <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          prod <= is_div ? div_next : mul_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= S_FIX;
        end
        S_FIX: begin
          // A zero divisor still runs the full iteration count, then forces the result.
          if (is_div && b_zero) begin
            hi   <= a_q;
            lo   <= '1;
            dz_q <= 1'b1;
          end else if (is_div) begin
            hi   <= rem_fix;
            lo   <= quo_fix;
            dz_q <= 1'b0;
          end else begin
            hi   <= mul_fix[2*WIDTH-1:WIDTH];
            lo   <= mul_fix[WIDTH-1:0];
            dz_q <= 1'b0;
          end
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state == S_CALC) || (state == S_FIX);
  assign done     = (state == S_DONE);
  assign div_zero = done & dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
// Latency expectations for zero-operand multiplies follow MDU_ZERO_SKIP_EN.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int   checkCount = 0;
  int   passCount = 0;
  int   latency;
  logic busyFirst;
  logic busyLast;
  logic doneSeen;
  logic [31:0] hiHeld;
  logic [31:0] loHeld;

`ifdef MDU_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 34;
`endif

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Launches one op, scrambles the operand inputs afterwards, optionally pokes start mid-op,
  // and waits (bounded) for done, leaving the caller at the negedge of the done cycle.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit poke);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    latency = 0; busyFirst = 1'b0; busyLast = 1'b0; doneSeen = 1'b0;
    while (!doneSeen && latency < 60) begin
      @(negedge clk);
      latency++;
      if (latency == 1) busyFirst = busy;
      if (latency == 33) busyLast = busy;
      if (done) doneSeen = 1'b1;
      if (poke && latency == 5) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      end
      if (latency == 6) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic checkFullOp(input string tag, input logic [31:0] expHi, input logic [31:0] expLo,
                             input logic expDz);
    checkOutput({tag, " done"}, {31'b0, doneSeen}, 32'd1);
    checkOutput({tag, " latency"}, 32'(latency), 32'd34);
    checkOutput({tag, " busy first"}, {31'b0, busyFirst}, 32'd1);
    checkOutput({tag, " busy last"}, {31'b0, busyLast}, 32'd1);
    checkOutput({tag, " busy at done"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, " hi"}, hi, expHi);
    checkOutput({tag, " lo"}, lo, expLo);
    checkOutput({tag, " div_zero"}, {31'b0, div_zero}, {31'b0, expDz});
  endtask

  initial begin
    $display("[TB] start");
    #1;
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset div_zero", {31'b0, div_zero}, 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // MULTU with a start poke mid-operation that must be ignored
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    checkFullOp("multu max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    hiHeld = hi; loHeld = lo;
    @(negedge clk);
    checkOutput("multu done pulse", {31'b0, done}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("multu hold hi", hi, hiHeld);
    checkOutput("multu hold lo", lo, loHeld);
    checkOutput("multu idle busy", {31'b0, busy}, 32'd0);

    applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd6, 1'b0);
    checkFullOp("mult neg", 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);

    applyStimulus(2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b0);
    checkFullOp("mult negneg", 32'h0000_0000, 32'h0000_002A, 1'b0);

    applyStimulus(2'b10, 32'hFFFF_FFEF, 32'd5, 1'b0);
    checkFullOp("div neg", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);

    applyStimulus(2'b10, 32'd17, 32'hFFFF_FFFB, 1'b0);
    checkFullOp("div negdivisor", 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);

    applyStimulus(2'b11, 32'd100, 32'd0, 1'b0);
    checkFullOp("divu zero", 32'd100, 32'hFFFF_FFFF, 1'b1);

    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checkFullOp("div overflow", 32'h0000_0000, 32'h8000_0000, 1'b0);

    applyStimulus(2'b11, 32'd100, 32'd7, 1'b0);
    checkFullOp("divu 100/7", 32'd2, 32'd14, 1'b0);

    applyStimulus(2'b00, 32'd0, 32'd123, 1'b0);
    checkOutput("mult zero done", {31'b0, doneSeen}, 32'd1);
    checkOutput("mult zero latency", 32'(latency), 32'(ZERO_LAT));
    checkOutput("mult zero busy first", {31'b0, busyFirst}, (ZERO_LAT == 1) ? 32'd0 : 32'd1);
    checkOutput("mult zero hi", hi, 32'd0);
    checkOutput("mult zero lo", lo, 32'd0);

    applyStimulus(2'b10, 32'hFFFF_FFEF, 32'd5, 1'b0);
    checkFullOp("div reload", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);

    // Launch DIV at edge k, poke start at k+5, assert reset before edge k+10
    @(negedge clk);
    op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'd5; b = 32'd1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("pre-reset busy", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort done", {31'b0, done}, 32'd0);
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    doneSeen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) doneSeen = 1'b1;
    end
    checkOutput("abort no done", {31'b0, doneSeen}, 32'd0);

    applyStimulus(2'b11, 32'd100, 32'd7, 1'b0);
    checkFullOp("after abort", 32'd2, 32'd14, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
